// File: rtl/fifo_pkg.sv
// Default geometry shared by the FIFO and anything that instantiates it.
package fifo_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 32;
   localparam int unsigned DEFAULT_DEPTH  = 16;
   localparam int unsigned DEFAULT_ADDR_W = 4;

endpackage

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered EMPTY/FULL/LAST flags.
module fifo
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic             CLKP,
   input  logic             RSTP,
   input  logic [WIDTH-1:0] DIP,
   input  logic             PUSHP,
   input  logic             POPP,
   output logic [WIDTH-1:0] DOP,
   output logic             EMPTYP,
   output logic             FULLP,
   output logic             LASTP
);

   localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] OneCnt  = (ADDR_W + 1)'(1);

   logic [WIDTH-1:0]  mem [0:DEPTH-1];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic              wr_en;
   logic              rd_en;

   assign wr_en = PUSHP & ~FULLP;
   assign rd_en = POPP & ~EMPTYP;

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en) begin
         count_nxt = count + OneCnt;
      end else if (rd_en && !wr_en) begin
         count_nxt = count - OneCnt;
      end
   end

   // Storage has no reset so it maps onto RAM; reset only blocks the write.
   always_ff @(posedge CLKP) begin
      if (wr_en && !RSTP) begin
         mem[wr_ptr] <= DIP;
      end
   end

   always_ff @(posedge CLKP) begin
      if (RSTP) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         DOP    <= '0;
         EMPTYP <= 1'b1;
         FULLP  <= 1'b0;
         LASTP  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            DOP    <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         count  <= count_nxt;
         EMPTYP <= (count_nxt == '0);
         FULLP  <= (count_nxt == FullCnt);
         LASTP  <= (count_nxt == OneCnt);
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the 32x16 FIFO: flags, ordering, wrap, full/empty corner cases, reset.
module tb_fifo;

   logic        CLKP;
   logic        RSTP;
   logic [31:0] DIP;
   logic        PUSHP;
   logic        POPP;
   logic [31:0] DOP;
   logic        EMPTYP;
   logic        FULLP;
   logic        LASTP;

   int checks = 0;
   int errors = 0;

   logic [31:0] vals [0:15] = '{
      32'h11000011, 32'h22000022, 32'h33000033, 32'h44000044,
      32'h55000055, 32'h66FF0066, 32'h77FFFF77, 32'h8800FF88,
      32'h99000099, 32'hAA0000AA, 32'hBB0000BB, 32'hCC0000CC,
      32'hDD0000DD, 32'hEE0000EE, 32'hFF0000FF, 32'hFFFFFFFF
   };

   fifo dut (
      .CLKP  (CLKP),
      .RSTP  (RSTP),
      .DIP   (DIP),
      .PUSHP (PUSHP),
      .POPP  (POPP),
      .DOP   (DOP),
      .EMPTYP(EMPTYP),
      .FULLP (FULLP),
      .LASTP (LASTP)
   );

   initial CLKP = 1'b0;
   always #5 CLKP = ~CLKP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic flags(input string tag, input logic e, input logic f, input logic l);
      chk({tag, ".empty"}, {31'd0, EMPTYP}, {31'd0, e});
      chk({tag, ".full"},  {31'd0, FULLP},  {31'd0, f});
      chk({tag, ".last"},  {31'd0, LASTP},  {31'd0, l});
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic rst, input logic push, input logic pop, input logic [31:0] d);
      RSTP  = rst;
      PUSHP = push;
      POPP  = pop;
      DIP   = d;
      @(posedge CLKP);
      #1;
      RSTP  = 1'b0;
      PUSHP = 1'b0;
      POPP  = 1'b0;
   endtask

   initial begin
      RSTP = 1'b0; PUSHP = 1'b0; POPP = 1'b0; DIP = '0;
      #2;

      // 1. reset and idle
      step(1'b1, 1'b1, 1'b1, 32'h12345678);
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, 1'b0, '0);
      flags("reset", 1'b1, 1'b0, 1'b0);
      chk("reset.dop", DOP, 32'h0);

      // 2. single push/pop
      step(1'b0, 1'b1, 1'b0, 32'h11000011);
      flags("push1", 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("pop1.dop", DOP, 32'h11000011);
      flags("pop1", 1'b1, 1'b0, 1'b0);

      // 3. fill to full, then a dropped 17th push
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, vals[i]);
         if (i == 0)  flags("fill0", 1'b0, 1'b0, 1'b1);
         if (i == 14) flags("fill14", 1'b0, 1'b0, 1'b0);
      end
      flags("full", 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h00000000);
      flags("push17", 1'b0, 1'b1, 1'b0);

      // 4. drain in order, then pops while empty hold DOP
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         chk($sformatf("drain%0d.dop", i), DOP, vals[i]);
         if (i == 0)  flags("drain0", 1'b0, 1'b0, 1'b0);
         if (i == 14) flags("drain14", 1'b0, 1'b0, 1'b1);
      end
      flags("drained", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("emptypop.dop", DOP, 32'hFFFFFFFF);
      flags("emptypop", 1'b1, 1'b0, 1'b0);

      // 5. fill 8, pop 4, push 12 to wrap pointers
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i));
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         chk($sformatf("wrap_pop%0d.dop", i), DOP, 32'h100 + 32'(i));
      end
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'h200 + 32'(i));
      flags("wrapfull", 1'b0, 1'b1, 1'b0);
      // push+pop at full: pop happens, push is dropped
      step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
      chk("fullpp.dop", DOP, 32'h104);
      flags("fullpp", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         chk($sformatf("wrap_drain%0d.dop", i), DOP,
             (i < 3) ? 32'h105 + 32'(i) : 32'h200 + 32'(i - 3));
      end
      flags("wrapempty", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("nodeadbeef.dop", DOP, 32'h20B);
      // push+pop at empty: push happens, pop is dropped
      step(1'b0, 1'b1, 1'b1, 32'h0000CAFE);
      chk("emptypp.dop", DOP, 32'h20B);
      flags("emptypp", 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("cafe.dop", DOP, 32'h0000CAFE);
      flags("cafe", 1'b1, 1'b0, 1'b0);

      // 6. 8 held, simultaneous push/pop streams through at constant occupancy
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h300 + 32'(i));
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b1, 32'h400 + 32'(i));
         chk($sformatf("pp%0d.dop", i), DOP,
             (i < 8) ? 32'h300 + 32'(i) : 32'h400 + 32'(i - 8));
      end
      flags("pp", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b1, '0);
         chk($sformatf("pp_drain%0d.dop", i), DOP, 32'h402 + 32'(i));
      end
      flags("pp_last", 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h500);
      chk("midstream.dop", DOP, 32'h409);
      step(1'b1, 1'b1, 1'b1, 32'h501);
      chk("midreset.dop", DOP, 32'h0);
      flags("midreset", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h00000005);
      step(1'b0, 1'b0, 1'b1, '0);
      chk("postreset.dop", DOP, 32'h00000005);
      flags("postreset", 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
